// File: rtl/adder_acc_pkg.sv
// Shared types and default widths for the adder result accumulator.
package adder_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    localparam int ADDER_OUT_W = 33;
    localparam int ACC_W       = 48;

endpackage

// File: rtl/adder_result_accumulator.sv
// Sums a programmed number of adder results into a wide accumulator and
// presents the total on a ready/valid port.
//
// state | meaning
// IDLE  | waiting for start; result port idle
// ACCUM | absorbing in_valid beats until count reaches the latched length
// HOLD  | total presented with acc_valid until acc_ready
module adder_result_accumulator
    import adder_acc_pkg::*;
#(
    parameter int IN_WIDTH    = ADDER_OUT_W,
    parameter int ACC_WIDTH   = ACC_W,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] length,
    input  logic                   in_valid,
    input  logic [IN_WIDTH-1:0]    in_data,
    output logic                   acc_valid,
    input  logic                   acc_ready,
    output logic [ACC_WIDTH-1:0]   acc_data,
    output logic                   acc_overflow,
    output logic                   busy,
    output logic                   drop_err
);

    acc_state_t             state_q, state_d;
    logic [COUNT_WIDTH-1:0] len_q, cnt_q, cnt_inc;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [ACC_WIDTH:0]     sum;
    logic                   ovf_q, drop_q;
    logic                   take_start, take_data, last_data;

    assign take_start = (state_q == IDLE) && start;
    assign take_data  = (state_q == ACCUM) && in_valid;
    assign cnt_inc    = cnt_q + COUNT_WIDTH'(1);
    assign last_data  = take_data && (cnt_inc == len_q);
    // Extra bit captures the carry out of the accumulator MSB.
    assign sum        = {1'b0, acc_q} + (ACC_WIDTH + 1)'(in_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (last_data) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (acc_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
    end

    assign acc_data     = acc_q;
    assign acc_overflow = ovf_q;
    assign drop_err     = drop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q  <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= 1'b0;
        end else if (take_start) begin
            len_q  <= length;
            cnt_q  <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            // A beat arriving with start is still a drop, so the clear loses to it.
            drop_q <= in_valid;
        end else if (take_data) begin
            acc_q <= sum[ACC_WIDTH-1:0];
            ovf_q <= ovf_q | sum[ACC_WIDTH];
            cnt_q <= cnt_inc;
        end else if (in_valid && (state_q != ACCUM)) begin
            drop_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Scoreboard bench for adder_result_accumulator: two instances (48-bit and
// 33-bit accumulators) share stimulus; batch totals come from a 64-bit model.
module tb_adder_result_accumulator;

    localparam int IW  = 33;
    localparam int AW  = 48;
    localparam int AWS = 33;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, acc_ready;
    logic [CW-1:0] length;
    logic [IW-1:0] in_data;

    logic          acc_valid, acc_overflow, busy, drop_err;
    logic [AW-1:0] acc_data;
    logic           s_valid, s_overflow, s_busy, s_drop;
    logic [AWS-1:0] s_data;

    int nvec  = 0;
    int nfail = 0;
    logic [63:0] sb_q[$];
    logic [IW-1:0] bdata[$];
    logic [63:0] mon_t;
    bit drop_exp;

    always #5 clk = ~clk;

    adder_result_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .in_valid(in_valid), .in_data(in_data), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .acc_data(acc_data), .acc_overflow(acc_overflow),
        .busy(busy), .drop_err(drop_err)
    );

    adder_result_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AWS), .COUNT_WIDTH(CW)) dut_s (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .in_valid(in_valid), .in_data(in_data), .acc_valid(s_valid),
        .acc_ready(acc_ready), .acc_data(s_data), .acc_overflow(s_overflow),
        .busy(s_busy), .drop_err(s_drop)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever a result is offered, compare against the oldest expected total.
    always @(negedge clk) begin
        if (!reset && (acc_valid || s_valid)) begin
            chk("valid_pair", 64'(s_valid), 64'(acc_valid));
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 64'({acc_valid, s_valid}), 64'(0));
            end else begin
                mon_t = sb_q[0];
                chk("acc_data", 64'(acc_data), 64'(mon_t[AW-1:0]));
                chk("acc_overflow", 64'(acc_overflow), 64'(|mon_t[63:AW]));
                chk("acc_data_w33", 64'(s_data), 64'(mon_t[AWS-1:0]));
                chk("acc_overflow_w33", 64'(s_overflow), 64'(|mon_t[63:AWS]));
                if (acc_ready) void'(sb_q.pop_front());
            end
        end
    end

    // rdy_delay < 0 holds acc_ready high from before the batch starts.
    task automatic run_batch(input int len, input bit gaps, input int rdy_delay, input bit noisy);
        logic [63:0]   total;
        logic [IW-1:0] d;
        int            k;
        bit            hs;
        total     = 64'd0;
        hs        = 1'b0;
        drop_exp  = 1'b0;
        acc_ready = (rdy_delay < 0);
        start     = 1'b1;
        length    = len[CW-1:0];
        in_valid  = 1'b0;
        if (len == 0) sb_q.push_back(64'd0);
        step();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("busy_after_start_w33", 64'(s_busy), 64'd1);
        chk("valid_after_start", 64'(acc_valid), 64'(len == 0));
        chk("drop_clear", 64'({drop_err, s_drop}), 64'd0);
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                k = $urandom_range(0, 2);
                repeat (k) begin
                    in_valid = 1'b0;
                    if (noisy) begin
                        start  = 1'b1;
                        length = 16'd9;
                    end
                    step();
                    start = 1'b0;
                end
            end
            if (bdata.size() > 0) d = bdata.pop_front();
            else d = {($urandom_range(0, 1) == 1), $urandom()};
            in_valid = 1'b1;
            in_data  = d;
            total    = total + 64'(d);
            if (i == len - 1) sb_q.push_back(total);
            step();
            in_valid = 1'b0;
            chk("valid_timing", 64'(acc_valid), 64'(i == len - 1));
        end
        for (int c = 0; c < 50 && !hs; c++) begin
            acc_ready = (rdy_delay < 0) || (c >= rdy_delay);
            if (noisy) begin
                start  = 1'b1;
                length = 16'd9;
                if ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b1;
                    in_data  = {1'b0, $urandom()};
                    drop_exp = 1'b1;
                end
            end
            hs = acc_ready;
            step();
            start    = 1'b0;
            in_valid = 1'b0;
        end
        acc_ready = 1'b0;
        chk("handshake_done", 64'(hs), 64'd1);
        chk("idle_valid", 64'({acc_valid, s_valid}), 64'd0);
        chk("idle_busy", 64'({busy, s_busy}), 64'd0);
        chk("drop_err", 64'(drop_err), 64'(drop_exp));
        chk("drop_err_w33", 64'(s_drop), 64'(drop_exp));
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        length    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        acc_ready = 1'b0;
        step();
        step();
        chk("rst_valid", 64'({acc_valid, s_valid}), 64'd0);
        chk("rst_busy", 64'({busy, s_busy}), 64'd0);
        chk("rst_data", 64'(acc_data), 64'd0);
        chk("rst_flags", 64'({acc_overflow, drop_err, s_overflow, s_drop}), 64'd0);
        reset = 1'b0;
        step();

        // Basic batch 1+2+3+4
        bdata = '{33'd1, 33'd2, 33'd3, 33'd4};
        run_batch(4, 1'b0, 0, 1'b0);

        // Gapped 5,7,9 with five cycles of backpressure
        bdata = '{33'd5, 33'd7, 33'd9};
        run_batch(3, 1'b1, 5, 1'b0);

        // Wraps the 33-bit instance to 1, fits in the 48-bit one
        bdata = '{33'h1_FFFF_FFFF, 33'h2};
        run_batch(2, 1'b0, 0, 1'b0);

        // Zero length with a beat dropped on the start cycle
        start    = 1'b1;
        length   = '0;
        in_valid = 1'b1;
        in_data  = 33'd9;
        sb_q.push_back(64'd0);
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("zero_len_valid", 64'(acc_valid), 64'd1);
        chk("zero_len_drop", 64'({drop_err, s_drop}), 64'b11);
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
        chk("zero_len_idle", 64'(acc_valid), 64'd0);
        chk("drop_sticky", 64'(drop_err), 64'd1);
        run_batch(2, 1'b0, 1, 1'b0);

        // Starts with length 9 during ACCUM and HOLD must be ignored
        run_batch(3, 1'b1, 3, 1'b1);

        // acc_ready held high before acc_valid
        run_batch(3, 1'b0, -1, 1'b0);
        run_batch(0, 1'b0, -1, 1'b0);

        // Reset mid-batch discards the partial sum
        start  = 1'b1;
        length = 16'd4;
        step();
        start = 1'b0;
        repeat (2) begin
            in_valid = 1'b1;
            in_data  = {1'b0, $urandom()};
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_valid", 64'({acc_valid, s_valid}), 64'd0);
        chk("midrst_busy", 64'({busy, s_busy}), 64'd0);
        chk("midrst_data", 64'(acc_data), 64'd0);
        chk("midrst_flags", 64'({acc_overflow, drop_err}), 64'd0);
        repeat (5) step();

        for (int n = 0; n < 40; n++) begin
            int len;
            len = ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(0, 6);
            run_batch(len, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 4) - 1, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/adder_result_accumulator.md
# adder_result_accumulator

Downstream consumer of the adder output stage. It sums a programmed number of adder results (`out` qualified by `output_valid`) into a wide accumulator. It then presents the total on a ready/valid result port. This lets the accelerator reduce a stream of pairwise sums to one value without host involvement.

## Interface
Parameters:
- `IN_WIDTH`, 33, width of the adder result consumed (matches adder `OUTPUT_DATA_WIDTH`)
- `ACC_WIDTH`, 48, accumulator and result width; must be ≥ `IN_WIDTH`
- `COUNT_WIDTH`, 16, width of the batch-length field

Ports:
- `clk`  in  1  single clock; all logic rising-edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a batch; honoured only in IDLE
- `length`  in  COUNT_WIDTH  number of results in the batch, sampled with `start`
- `in_valid`  in  1  adder `output_valid`
- `in_data`  in  IN_WIDTH  adder `out`, unsigned
- `acc_valid`  out  1  result available
- `acc_ready`  in  1  downstream accepts result
- `acc_data`  out  ACC_WIDTH  accumulated total
- `acc_overflow`  out  1  batch total exceeded ACC_WIDTH (wrapped)
- `busy`  out  1  high in ACCUM or HOLD
- `drop_err`  out  1  sticky; an `in_valid` arrived outside ACCUM

## Operation
- The adder stage has no backpressure. Every `in_valid` seen in ACCUM must be absorbed the same cycle.
- States: IDLE, ACCUM, HOLD.
- IDLE, `start`=1:
  - Latch `length`.
  - Clear the accumulator, counter, `acc_overflow` and `drop_err`.
  - Go to ACCUM, or to HOLD if `length`=0 (result 0).
- ACCUM, `in_valid`=1:
  - acc ← acc + zero-extend(`in_data`), modulo 2^ACC_WIDTH.
  - Carry out of the MSB sets `acc_overflow`.
  - Counter increments.
  - When the counter reaches `length`, go to HOLD.
- ACCUM, `in_valid`=0: hold all state.
- HOLD:
  - `acc_valid`=1 and `acc_data`/`acc_overflow` stay stable until `acc_ready`=1.
  - On the handshake, go to IDLE.
- `in_valid` in IDLE or HOLD: data discarded, `drop_err` set. This includes the `start` cycle itself.
- `start` outside IDLE is ignored.
- Reset values: state IDLE, `acc_valid`=0, `acc_data`=0, `acc_overflow`=0, `busy`=0, `drop_err`=0.
- Reset mid-batch: the partial sum is discarded and no result is emitted.

## Timing
- `start` accepted at cycle t → `busy`=1 at t+1; the first accepted `in_valid` is at t+1.
- Last (Nth) `in_valid` at cycle t → `acc_valid`=1 with final `acc_data` at t+1.
- `length`=0: `start` at t → `acc_valid`=1 at t+1, `acc_data`=0.
- Handshake at cycle t (`acc_valid` & `acc_ready`):
  - State IDLE, `acc_valid`=0 and `busy`=0 at t+1.
  - A new `start` is accepted at t+1, not at t.
- `acc_ready` held high before `acc_valid`: the handshake completes on the first `acc_valid` cycle.
- `acc_data` is registered; there is no combinational path from `in_*` to `acc_*`.
- `drop_err` asserts the cycle after the offending `in_valid` and holds until the next accepted `start` or `reset`.
- Maximum batch is 2^COUNT_WIDTH − 1 results. The counter never wraps within a batch.

## Structure
- Shared package `adder_acc_pkg`:
  - `acc_state_t` enum (IDLE, ACCUM, HOLD).
  - Default width constants `ADDER_OUT_W`=33 and `ACC_W`=48.
- Single module. The counter and accumulator stay inline and no sub-module is warranted.
- Optional wrapper port mapping onto the adder output interface's `async_rcv` modport plus `output_valid`; the core module keeps plain ports.

## Test plan
- Basic batch:
  - Stimulus: `start`, `length`=4; `in_data` 1, 2, 3, 4 on consecutive cycles; `acc_ready`=1.
  - Required: `acc_valid` one cycle after the 4th input, `acc_data`=10, `acc_overflow`=0, IDLE next cycle.
- Gapped input and backpressure:
  - Stimulus: `length`=3; inputs 5, 7, 9 with idle gaps; `acc_ready`=0 for 5 cycles.
  - Required: `acc_data`=21 held stable with `acc_valid`=1 until `acc_ready`; exactly one handshake.
- Overflow:
  - Stimulus: `ACC_WIDTH`=33, `IN_WIDTH`=33; `length`=2; inputs 0x1_FFFF_FFFF and 0x2.
  - Required: `acc_data`=0x1, `acc_overflow`=1.
- Zero length and dropped data:
  - Stimulus: `start` with `length`=0 and `in_valid`=1 (data 9) in the same cycle.
  - Required: `acc_valid` next cycle with `acc_data`=0; `drop_err`=1.
  - Then stimulus: a new `start`.
  - Required: `drop_err` clears.
- Ignored start:
  - Stimulus: `start` pulses in ACCUM and in HOLD, with `length`=9.
  - Required: original `length` (3) is unchanged; the batch completes normally.
- Reset mid-batch:
  - Stimulus: `length`=4, 2 inputs accepted, then `reset` for 1 cycle.
  - Required: next cycle IDLE with all outputs 0 and no `acc_valid` ever emitted for that batch.
